// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and limits for the unified-memory port arbiter
package mem_arb_pkg;
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
    typedef enum logic {OWN_IF = 1'b0, OWN_DM = 1'b1} owner_t;
    localparam int MEM_LAT_MAX = 15;
endpackage

// File: rtl/mem_arb_lat_cnt.sv
// mem_arb_lat_cnt: loadable down-counter timing the fixed memory latency
module mem_arb_lat_cnt
    import mem_arb_pkg::*;
#(
    parameter int W = $clog2(MEM_LAT_MAX + 1)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic         dec,
    input  logic [W-1:0] load_val,
    output logic         done
);
    logic [W-1:0] cnt;
    // reload at every issue, count down while waiting for read data
    always_ff @(posedge clk) begin
        if (reset)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (dec)
            cnt <= cnt - 1'b1;
    end
    assign done = cnt == W'(1);
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: serialises IF and MEM stage accesses onto one fixed-latency memory port; ARB_RR_EN selects round-robin tie-break
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_ack,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              pipe_stall
);
    localparam int CW = $clog2(MEM_LAT + 1);

    state_t state, state_nx;
    owner_t owner, grant;
    logic   lat_we;
    logic   cnt_done;

`ifdef ARB_RR_EN
    // owner still names the last-served side while idle, so a tie goes to the other one
    assign grant = (dm_req && (!if_req || owner == OWN_IF)) ? OWN_DM : OWN_IF;
`else
    // MEM stage holds the older instruction, so it always wins
    assign grant = dm_req ? OWN_DM : OWN_IF;
`endif

    mem_arb_lat_cnt #(.W(CW)) u_lat_cnt (
        .clk      (clk),
        .reset    (reset),
        .load     (state == ISSUE),
        .dec      (state == WAIT),
        .load_val (CW'(MEM_LAT - 1)),
        .done     (cnt_done)
    );

    // next state: requests are only looked at in IDLE, never in DONE
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = (if_req || dm_req) ? ISSUE : IDLE;
            ISSUE:   state_nx = (MEM_LAT == 1) ? DONE : WAIT;
            WAIT:    state_nx = cnt_done ? DONE : WAIT;
            default: state_nx = IDLE;
        endcase
    end

    // state register plus the granted request's fields, held stable until the next grant
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            owner     <= OWN_IF;
            lat_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && (if_req || dm_req)) begin
                owner     <= grant;
                lat_we    <= grant == OWN_DM && dm_we;
                mem_addr  <= grant == OWN_DM ? dm_addr : if_addr;
                mem_wdata <= grant == OWN_DM ? dm_wdata : '0;
            end
        end
    end

    assign mem_en     = state == ISSUE;
    assign mem_we     = lat_we && owner == OWN_DM;
    assign if_ack     = state == DONE && owner == OWN_IF;
    assign dm_ack     = state == DONE && owner == OWN_DM;
    assign if_rdata   = if_ack ? mem_rdata : '0;
    assign dm_rdata   = (dm_ack && !lat_we) ? mem_rdata : '0;
    assign pipe_stall = !reset && ((if_req && !if_ack) || (dm_req && !dm_ack));
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed and random checks of the arbiter against a transaction-phase model
module tb_mem_port_arbiter;
    localparam int L = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, if_req, dm_req, dm_we;
    logic [31:0] if_addr, dm_addr, dm_wdata;
    logic        if_ack, dm_ack, mem_en, mem_we, pipe_stall;
    logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata, mem_rdata;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(L)) u_dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_ack(dm_ack), .dm_rdata(dm_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .pipe_stall(pipe_stall)
    );

    logic        if_req2, dm_req2, dm_we2;
    logic [31:0] if_addr2, dm_addr2, dm_wdata2;
    logic        if_ack2, dm_ack2, mem_en2, mem_we2, pipe_stall2;
    logic [31:0] if_rdata2, dm_rdata2, mem_addr2, mem_wdata2, mem_rdata2;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) u_dut1 (
        .clk(clk), .reset(reset),
        .if_req(if_req2), .if_addr(if_addr2), .if_ack(if_ack2), .if_rdata(if_rdata2),
        .dm_req(dm_req2), .dm_we(dm_we2), .dm_addr(dm_addr2), .dm_wdata(dm_wdata2),
        .dm_ack(dm_ack2), .dm_rdata(dm_rdata2),
        .mem_en(mem_en2), .mem_we(mem_we2), .mem_addr(mem_addr2), .mem_wdata(mem_wdata2),
        .mem_rdata(mem_rdata2), .pipe_stall(pipe_stall2)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] init_val(logic [31:0] a);
        return a ^ 32'h5A5A_5A5A;
    endfunction

    logic [31:0] emem [logic [31:0]];
    logic [31:0] pipe [L];
    always @(posedge clk) begin
        pipe[0] <= mem_en ? (emem.exists(mem_addr) ? emem[mem_addr] : init_val(mem_addr))
                          : 32'hBAD0_0000 ^ 32'(cyc);
        for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
        if (mem_en && mem_we) emem[mem_addr] = mem_wdata;
    end
    assign mem_rdata = pipe[L-1];

    always @(posedge clk) mem_rdata2 <= mem_en2 ? ~mem_addr2 : 32'h0BAD_0BAD;

    int checks = 0, errors = 0;
    int p = 0, p_nx = 0;
    logic m_dm = 0, m_last_dm = 0, m_we = 0;
    logic [31:0] m_addr = 0, m_wdata = 0, m_data = 0;
    logic [31:0] smem [logic [31:0]];
    logic e_if_ack = 0, e_dm_ack = 0;
    logic if_ack_now = 0, if_ack_last = 0, dm_ack_now = 0, dm_ack_last = 0;
    logic ack_q [$];
    int   issue_q [$];

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rd_shadow(logic [31:0] a);
        return smem.exists(a) ? smem[a] : init_val(a);
    endfunction

    task automatic tick();
        logic win_dm;
        #1;
        chk("pipe_stall", pipe_stall, reset ? 1'b0 : ((if_req && !e_if_ack) || (dm_req && !e_dm_ack)));
        if (reset) begin
            p_nx = 0;
            m_last_dm = 0;
        end else if (p == 0 && (if_req || dm_req)) begin
`ifdef ARB_RR_EN
            win_dm = dm_req && (!if_req || !m_last_dm);
`else
            win_dm = dm_req;
`endif
            m_dm = win_dm;
            m_last_dm = win_dm;
            m_we = win_dm && dm_we;
            m_addr = win_dm ? dm_addr : if_addr;
            m_wdata = win_dm ? dm_wdata : 32'h0;
            m_data = m_we ? 32'h0 : rd_shadow(m_addr);
            if (m_we) smem[m_addr] = m_wdata;
            p_nx = 1;
        end else
            p_nx = (p == 0 || p == L + 1) ? 0 : p + 1;
        @(posedge clk); #1;
        p = p_nx;
        e_if_ack = p == L + 1 && !m_dm;
        e_dm_ack = p == L + 1 && m_dm;
        chk("mem_en", mem_en, p == 1);
        if (p >= 1) begin
            chk("mem_addr", mem_addr, m_addr);
            chk("mem_we", mem_we, m_we);
            chk("mem_wdata", mem_wdata, m_wdata);
        end
        chk("if_ack", if_ack, e_if_ack);
        chk("dm_ack", dm_ack, e_dm_ack);
        chk("if_rdata", if_rdata, e_if_ack ? m_data : 32'h0);
        chk("dm_rdata", dm_rdata, e_dm_ack ? m_data : 32'h0);
        if (if_ack || dm_ack) ack_q.push_back(dm_ack);
        if (mem_en) issue_q.push_back(cyc);
        if_ack_last = if_ack_now;
        if_ack_now = if_ack;
        dm_ack_last = dm_ack_now;
        dm_ack_now = dm_ack;
    endtask

    task automatic serve();
        if (if_req && if_ack_last) if_req = 0;
        if (dm_req && dm_ack_last) dm_req = 0;
    endtask

    task automatic drain(int n);
        for (int i = 0; i < n && (if_req || dm_req || p != 0); i++) begin
            tick();
            serve();
        end
        chk("drain_timeout", (if_req || dm_req || p != 0), 1'b0);
    endtask

    initial begin
        reset = 1; if_req = 0; dm_req = 0; dm_we = 0;
        if_addr = 0; dm_addr = 0; dm_wdata = 0;
        if_req2 = 0; dm_req2 = 0; dm_we2 = 0; if_addr2 = 0; dm_addr2 = 0; dm_wdata2 = 0;
        emem[32'h40] = 32'h2008_0005;
        smem[32'h40] = 32'h2008_0005;
        @(posedge clk); #1;
        tick();
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_wdata", mem_wdata, 32'h0);
        chk("rst_mem_we", mem_we, 1'b0);
        chk("rst_stall", pipe_stall, 1'b0);
        reset = 0;
        tick();

        // lone fetch
        if_addr = 32'h40; if_req = 1;
        tick();
        chk("f_issue_en", mem_en, 1'b1);
        chk("f_issue_addr", mem_addr, 32'h40);
        chk("f_issue_we", mem_we, 1'b0);
        tick();
        chk("f_wait_stall", pipe_stall, 1'b1);
        tick();
        chk("f_ack", if_ack, 1'b1);
        chk("f_rdata", if_rdata, 32'h2008_0005);
        drain(10);

        // simultaneous requests: DM first, IF four cycles later
        ack_q.delete(); issue_q.delete();
        if_addr = 32'h200; dm_addr = 32'h300; dm_we = 0;
        if_req = 1; dm_req = 1;
        drain(20);
        chk("tie_acks", ack_q.size(), 2);
        if (ack_q.size() == 2) begin
            chk("tie_first_dm", ack_q[0], 1'b1);
            chk("tie_second_if", ack_q[1], 1'b0);
        end
        if (issue_q.size() == 2) chk("tie_issue_gap", issue_q[1] - issue_q[0], 4);
        else chk("tie_issues", issue_q.size(), 2);

        // continuous contention for three rounds
        ack_q.delete();
        if_addr = 32'h400; dm_addr = 32'h500;
        if_req = 1; dm_req = 1;
        for (int i = 0; i < 40 && ack_q.size() < 3; i++) begin
            tick();
            if (if_ack_last) if_addr += 4;
            if (dm_ack_last) dm_addr += 4;
        end
        tick();
        if_req = 0; dm_req = 0;
        drain(20);
        chk("cont_rounds", ack_q.size() >= 3, 1'b1);
        if (ack_q.size() >= 3) begin
`ifdef ARB_RR_EN
            chk("cont_r1", ack_q[0], 1'b1);
            chk("cont_r2", ack_q[1], 1'b0);
            chk("cont_r3", ack_q[2], 1'b1);
`else
            chk("cont_r1", ack_q[0], 1'b1);
            chk("cont_r2", ack_q[1], 1'b1);
            chk("cont_r3", ack_q[2], 1'b1);
`endif
        end

        // lone store, then load it back
        dm_we = 1; dm_addr = 32'h100; dm_wdata = 32'hDEAD_BEEF; dm_req = 1;
        tick();
        chk("st_en", mem_en, 1'b1);
        chk("st_we", mem_we, 1'b1);
        chk("st_addr", mem_addr, 32'h100);
        chk("st_wdata", mem_wdata, 32'hDEAD_BEEF);
        tick(); tick();
        chk("st_ack", dm_ack, 1'b1);
        chk("st_rdata", dm_rdata, 32'h0);
        drain(10);
        dm_we = 0; dm_req = 1;
        tick(); tick(); tick();
        chk("ld_back", dm_rdata, 32'hDEAD_BEEF);
        drain(10);

        // reset while waiting on memory
        if_addr = 32'h40; if_req = 1;
        tick(); tick();
        chk("rw_in_wait", mem_en, 1'b0);
        reset = 1;
        tick();
        chk("rw_en", mem_en, 1'b0);
        chk("rw_we", mem_we, 1'b0);
        chk("rw_addr", mem_addr, 32'h0);
        chk("rw_wdata", mem_wdata, 32'h0);
        chk("rw_if_ack", if_ack, 1'b0);
        chk("rw_dm_ack", dm_ack, 1'b0);
        chk("rw_if_rdata", if_rdata, 32'h0);
        chk("rw_stall", pipe_stall, 1'b0);
        reset = 0; if_req = 0;
        tick(); tick(); tick();
        ack_q.delete();
        if_addr = 32'h48; if_req = 1;
        drain(10);
        chk("rw_fresh_ack", ack_q.size(), 1);

        // randomized traffic with rare resets
        for (int i = 0; i < 400; i++) begin
            tick();
            reset = ($urandom_range(0, 79) == 0);
            if (if_req && if_ack_last) if_req = $urandom_range(0, 1);
            else if (!if_req && $urandom_range(0, 2) == 0) if_req = 1;
            if (if_req && (if_ack_last || !if_ack_now)) if_addr = 32'h1000 + 32'($urandom_range(0, 7)) * 4;
            if (dm_req && dm_ack_last) dm_req = $urandom_range(0, 1);
            else if (!dm_req && $urandom_range(0, 2) == 0) dm_req = 1;
            if (dm_req && (dm_ack_last || p == 0) && !(p == 0 && !dm_ack_last && dm_req && checks < 0)) begin
                if (p == 0 || dm_ack_last) begin
                    dm_addr = 32'h1000 + 32'($urandom_range(0, 7)) * 4;
                    dm_we = $urandom_range(0, 1);
                    dm_wdata = $urandom;
                end
            end
        end
        reset = 0; if_req = 0; dm_req = 0;
        drain(20);

        // MEM_LAT=1 instance under a held fetch request
        if_addr2 = 32'h80; if_req2 = 1;
        for (int k = 1; k <= 12; k++) begin
            tick();
            chk("l1_mem_en", mem_en2, (k % 3) == 1);
            chk("l1_ack", if_ack2, (k % 3) == 2);
            chk("l1_rdata", if_rdata2, (k % 3) == 2 ? ~32'h80 : 32'h0);
            chk("l1_dm_ack", dm_ack2, 1'b0);
            chk("l1_stall", pipe_stall2, (k % 3) != 2);
        end
        if_req2 = 0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
